uart_tx_pin: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_counter.sv | 29 ++
 rtl/uart_tx_pin.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 104;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int data_bits,
                                      input int stop_bits,
                                      input int clks_per_bit);
    return (1 + data_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick on the last count.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_pin.sv
// UART transmitter: accepts a word over valid/ready and serialises it LSB first onto a registered pin.
module uart_tx_pin
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_pin: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_pin: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_pin: STOP_BITS must be 1 or 2");
  end

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 tick;
  logic                 accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock (clock),
    .rst_n (rst_n),
    .clear (accept),
    .enable(state != IDLE),
    .tick  (tick)
  );

  // tx is loaded one state ahead so the pin changes on the same edge as the state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_data;
            tx        <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
